// File: rtl/md_pkg.sv
// Shared definitions for the position ring controller.
// Dispatch codes, controller states and a saturating counter helper.
package md_pkg;

  localparam logic [1:0] DISP_CLEAR = 2'b11;
  localparam logic [1:0] DISP_GO    = 2'b01;
  localparam logic [1:0] DISP_HOLD  = 2'b10;
  localparam logic [1:0] DISP_RUN   = 2'b00;

  localparam int NNODES_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DISPATCH,
    ST_RUN_ACK,
    ST_WAIT_Q,
    ST_FLUSH_ACK,
    ST_SWAP
  } state_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/position_ring_ctrl_if.sv
// Ring-side bundle: node status in, dispatch/buffer/neighbor handshake out.
// master = controller, slave = ring nodes plus force/update consumers.
interface position_ring_ctrl_if
  import md_pkg::*;
#(
  parameter int NNODES = NNODES_DEF
);

  logic [NNODES-1:0] node_done_batch;
  logic [NNODES-1:0] node_done_all;
  logic [NNODES-1:0] node_in_flight;
  logic              nbr_ack;
  logic              swap_ok;
  logic [1:0]        dispatch;
  logic              double_buffer;
  logic              nbr_valid;

  modport master (
    input  node_done_batch,
    input  node_done_all,
    input  node_in_flight,
    input  nbr_ack,
    input  swap_ok,
    output dispatch,
    output double_buffer,
    output nbr_valid
  );

  modport slave (
    output node_done_batch,
    output node_done_all,
    output node_in_flight,
    output nbr_ack,
    output swap_ok,
    input  dispatch,
    input  double_buffer,
    input  nbr_valid
  );

endinterface

// File: rtl/ring_quiet_detect.sv
// Batch-end detector: counts consecutive quiet ring cycles up to DRAIN.
// clr_i holds the count at zero; finished_o pulses when DRAIN is reached.
module ring_quiet_detect #(
  parameter int NNODES = 8,
  parameter int DRAIN  = 2
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [NNODES-1:0] done_batch_i,
  input  logic [NNODES-1:0] in_flight_i,
  output logic              finished_o
);

  localparam int CW = $clog2(DRAIN + 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          quiet;

  assign quiet      = (&done_batch_i) && !(|in_flight_i);
  assign finished_o = (cnt_q == CW'(DRAIN));

  // Restart after reporting so the flag is a single-cycle pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !quiet || finished_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/position_ring_ctrl.sv
// Timestep sequencer for one ring of position nodes.
// Ports: clk/reset, start/num_steps, ring bundle, status and counters.
module position_ring_ctrl
  import md_pkg::*;
#(
  parameter int NNODES = NNODES_DEF,
  parameter int DRAIN  = 2,
  parameter int TSW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TSW-1:0]       num_steps,
  position_ring_ctrl_if.master ring,
  output logic                 busy,
  output logic                 step_done,
  output logic                 run_done,
  output logic [TSW-1:0]       step_count,
  output logic [15:0]          batch_count
);

  state_e         state_q;
  logic [1:0]     disp_q;
  logic           db_q;
  logic           nv_q;
  logic           busy_q;
  logic           sd_q;
  logic           rd_q;
  logic           fin_q;
  logic [TSW-1:0] steps_q;
  logic [TSW-1:0] step_cnt_q;
  logic [15:0]    batch_q;
  logic           finished;

  ring_quiet_detect #(
    .NNODES (NNODES),
    .DRAIN  (DRAIN)
  ) u_quiet (
    .clk          (clk),
    .rst_ni       (reset),
    .clr_i        (state_q != ST_WAIT_Q),
    .done_batch_i (ring.node_done_batch),
    .in_flight_i  (ring.node_in_flight),
    .finished_o   (finished)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      disp_q     <= DISP_RUN;
      db_q       <= 1'b0;
      nv_q       <= 1'b0;
      busy_q     <= 1'b0;
      sd_q       <= 1'b0;
      rd_q       <= 1'b0;
      fin_q      <= 1'b0;
      steps_q    <= '0;
      step_cnt_q <= '0;
      batch_q    <= '0;
    end else begin
      sd_q <= 1'b0;
      rd_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            steps_q    <= (num_steps == '0) ? TSW'(1) : num_steps;
            step_cnt_q <= '0;
            batch_q    <= '0;
            fin_q      <= 1'b0;
            busy_q     <= 1'b1;
            disp_q     <= DISP_CLEAR;
            state_q    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          batch_q <= sat_inc16(batch_q);
          disp_q  <= DISP_GO;
          state_q <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (fin_q) begin
            nv_q    <= 1'b1;
            disp_q  <= DISP_HOLD;
            state_q <= ST_FLUSH_ACK;
          end else if (batch_q == 16'd1) begin
            // First batch only carries the reset neighbor pattern.
            disp_q  <= DISP_RUN;
            state_q <= ST_WAIT_Q;
          end else begin
            nv_q    <= 1'b1;
            disp_q  <= DISP_HOLD;
            state_q <= ST_RUN_ACK;
          end
        end
        ST_RUN_ACK: begin
          if (ring.nbr_ack) begin
            nv_q    <= 1'b0;
            disp_q  <= DISP_RUN;
            state_q <= ST_WAIT_Q;
          end
        end
        ST_WAIT_Q: begin
          if (finished) begin
            fin_q   <= &ring.node_done_all;
            batch_q <= sat_inc16(batch_q);
            disp_q  <= DISP_GO;
            state_q <= ST_DISPATCH;
          end
        end
        ST_FLUSH_ACK: begin
          if (ring.nbr_ack) begin
            nv_q    <= 1'b0;
            disp_q  <= DISP_RUN;
            state_q <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          if (ring.swap_ok) begin
            db_q       <= ~db_q;
            step_cnt_q <= step_cnt_q + TSW'(1);
            sd_q       <= 1'b1;
            fin_q      <= 1'b0;
            if (step_cnt_q + TSW'(1) == steps_q) begin
              rd_q    <= 1'b1;
              busy_q  <= 1'b0;
              disp_q  <= DISP_RUN;
              state_q <= ST_IDLE;
            end else begin
              batch_q <= '0;
              disp_q  <= DISP_CLEAR;
              state_q <= ST_CLEAR;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          nv_q    <= 1'b0;
          disp_q  <= DISP_RUN;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ring.dispatch      = disp_q;
  assign ring.double_buffer = db_q;
  assign ring.nbr_valid     = nv_q;
  assign busy               = busy_q;
  assign step_done          = sd_q;
  assign run_done           = rd_q;
  assign step_count         = step_cnt_q;
  assign batch_count        = batch_q;

endmodule

// File: tb/tb_position_ring_ctrl.sv
// Directed bench for position_ring_ctrl with a small reactive ring model.
// Expected cycle positions below are hand-derived for NNODES=4, DRAIN=2.
module tb_position_ring_ctrl;
  import md_pkg::*;

  localparam int NN   = 4;
  localparam int TSW  = 16;
  localparam int QLAT = 5;
  localparam int ACKL = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [TSW-1:0] num_steps;
  logic           busy;
  logic           step_done;
  logic           run_done;
  logic [TSW-1:0] step_count;
  logic [15:0]    batch_count;

  int n_chk = 0;
  int n_fail = 0;

  int ndisp, qcnt, vcnt, da_after;
  logic [NN-1:0] da_part;

  int t, n_go, n_clr, n_hold, n_nv, n_sd, n_rd, n_both, first_clr, bs_at;
  logic rd_seen;
  logic [7:0] db_hist;

  position_ring_ctrl_if #(.NNODES(NN)) ring();

  position_ring_ctrl #(
    .NNODES (NN),
    .DRAIN  (2),
    .TSW    (TSW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_steps   (num_steps),
    .ring        (ring.master),
    .busy        (busy),
    .step_done   (step_done),
    .run_done    (run_done),
    .step_count  (step_count),
    .batch_count (batch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    ndisp = 0;
    qcnt  = 0;
    vcnt  = 0;
    ring.node_done_batch = '1;
    ring.node_done_all   = '0;
    ring.node_in_flight  = '0;
    ring.nbr_ack         = 1'b0;
  endtask

  // Nodes go busy on each dispatch and turn quiet QLAT cycles later;
  // ack follows ACKL cycles after nbr_valid is seen.
  task automatic model_upd();
    if (ring.dispatch == 2'b11) ndisp = 0;
    if (ring.dispatch == 2'b01) begin
      ndisp++;
      qcnt = QLAT;
      ring.node_done_batch = '0;
      ring.node_done_all   = '0;
    end else if (qcnt > 0) begin
      qcnt--;
      if (qcnt == 0) begin
        ring.node_done_batch = '1;
        ring.node_done_all   = (ndisp >= da_after) ? '1 : da_part;
      end
    end
    if (ring.nbr_valid) begin
      if (vcnt == ACKL) ring.nbr_ack = 1'b1;
      else vcnt++;
    end else begin
      vcnt = 0;
      ring.nbr_ack = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      model_upd();
      tick();
      start = 1'b0;
    end
  endtask

  task automatic run(input int budget);
    t = 0; n_go = 0; n_clr = 0; n_hold = 0; n_nv = 0;
    n_sd = 0; n_rd = 0; n_both = 0; first_clr = -1;
    rd_seen = 1'b0; db_hist = '0;
    while (t < budget && !rd_seen) begin
      model_upd();
      tick();
      t++;
      start = 1'b0;
      if (ring.dispatch == 2'b01) n_go++;
      if (ring.dispatch == 2'b10) n_hold++;
      if (ring.dispatch == 2'b11) begin
        n_clr++;
        if (first_clr < 0) first_clr = t;
      end
      if (ring.nbr_valid) n_nv++;
      if (step_done) begin
        n_sd++;
        db_hist = {db_hist[6:0], ring.double_buffer};
      end
      if (run_done) begin
        n_rd++;
        rd_seen = 1'b1;
      end
      if (step_done && run_done) n_both++;
      if (t == bs_at) start = 1'b1;
    end
    chk("run_done_seen", rd_seen, 1);
  endtask

  logic [NN-1:0] v_db [6];
  logic [NN-1:0] v_if [6];
  logic [1:0]    v_ex [6];

  initial begin
    reset = 1'b0;
    start = 1'b1;
    num_steps = '0;
    ring.swap_ok = 1'b1;
    da_after = 3;
    da_part  = '0;
    bs_at    = -1;
    model_init();

    // Reset held with start asserted
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_disp", ring.dispatch, 0);
    chk("rst_db", ring.double_buffer, 0);
    chk("rst_nv", ring.nbr_valid, 0);
    chk("rst_sd", step_done, 0);
    chk("rst_rd", run_done, 0);
    chk("rst_sc", step_count, 0);
    chk("rst_bc", batch_count, 0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_disp", ring.dispatch, 0);

    // Single step, done_all after batch 3
    num_steps = 16'd1;
    start = 1'b1;
    run(200);
    chk("s1_cycles", t, 31);
    chk("s1_first_clr", first_clr, 1);
    chk("s1_n_clr", n_clr, 1);
    chk("s1_n_go", n_go, 4);
    chk("s1_n_hold", n_hold, 9);
    chk("s1_n_nv", n_nv, 9);
    chk("s1_n_sd", n_sd, 1);
    chk("s1_both", n_both, 1);
    chk("s1_bc", batch_count, 4);
    chk("s1_sc", step_count, 1);
    chk("s1_db", ring.double_buffer, 1);
    chk("s1_busy", busy, 0);
    tick();
    chk("s1_sd_pulse", step_done, 0);
    chk("s1_rd_pulse", run_done, 0);

    // Drain guard, then async abort during RUN_ACK
    v_db = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    v_if = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
    v_ex = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    model_init();
    num_steps = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dg_clear", ring.dispatch, 2'b11);
    tick();
    chk("dg_go1", ring.dispatch, 2'b01);
    chk("dg_bc1", batch_count, 1);
    for (int i = 0; i < 6; i++) begin
      ring.node_done_batch = v_db[i];
      ring.node_in_flight  = v_if[i];
      tick();
      chk($sformatf("dg_disp_c%0d", i + 3), ring.dispatch, v_ex[i]);
    end
    chk("dg_bc2", batch_count, 2);
    ring.node_done_batch = '0;
    tick();
    chk("ra_disp", ring.dispatch, 2'b10);
    chk("ra_nv", ring.nbr_valid, 1);
    chk("ra_db", ring.double_buffer, 1);
    reset = 1'b0;
    #1;
    chk("abort_disp", ring.dispatch, 0);
    chk("abort_nv", ring.nbr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_db", ring.double_buffer, 0);
    chk("abort_bc", batch_count, 0);
    #3;
    reset = 1'b1;
    tick();
    tick();
    chk("abort_idle", busy, 0);

    // Partial done_all, num_steps=0 acts as 1
    model_init();
    da_after = 2;
    da_part  = 4'b0111;
    num_steps = '0;
    start = 1'b1;
    run(200);
    chk("pa_cycles", t, 23);
    chk("pa_n_go", n_go, 3);
    chk("pa_n_hold", n_hold, 6);
    chk("pa_bc", batch_count, 3);
    chk("pa_sc", step_count, 1);
    chk("pa_db", ring.double_buffer, 1);

    // Swap stall, three steps, start while busy
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    model_init();
    da_after = 1;
    da_part  = '0;
    ring.swap_ok = 1'b0;
    num_steps = 16'd3;
    start = 1'b1;
    cycles(34);
    chk("st_busy", busy, 1);
    chk("st_db", ring.double_buffer, 0);
    chk("st_disp", ring.dispatch, 0);
    chk("st_sc", step_count, 0);
    chk("st_bc", batch_count, 2);
    ring.swap_ok = 1'b1;
    tick();
    chk("st_db_tog", ring.double_buffer, 1);
    chk("st_sd", step_done, 1);
    chk("st_clear", ring.dispatch, 2'b11);
    chk("st_sc1", step_count, 1);
    chk("st_bc0", batch_count, 0);
    bs_at = 5;
    run(300);
    bs_at = -1;
    chk("st_n_sd", n_sd, 2);
    chk("st_db_hist", db_hist[1:0], 2'b01);
    chk("st_sc3", step_count, 3);
    chk("st_db_end", ring.double_buffer, 1);
    tick();
    tick();
    chk("st_no_restart", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/position_ring_ctrl.md
Name: position_ring_ctrl

Overview:
- Sequences one ring of position ring nodes through a timestep.
- Drives the shared dispatch code and double-buffer select. Watches per-node done_batch, done_all and in_flight to detect the end of each batch and the end of the cell sweep.
- Hands each batch's latched neighbor sets to the force pipeline with a valid/ack handshake.
- Swaps the position double buffer between timesteps once the update side grants it.

Parameters:
- NNODES, 8, number of ring nodes supervised.
- DRAIN, 2, consecutive quiet cycles required before a batch counts as finished (covers ring hop latency).
- TSW, 16, width of the timestep counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a run of num_steps timesteps; ignored unless IDLE.
- num_steps  in  TSW  timesteps per run; sampled on accepted start; 0 is treated as 1.
- node_done_batch  in  NNODES  per-node done_batch.
- node_done_all  in  NNODES  per-node done_all.
- node_in_flight  in  NNODES  per-node in_flight.
- nbr_ack  in  1  force pipeline has consumed the current neighbor sets.
- swap_ok  in  1  update side has finished with the inactive buffer.
- dispatch  out  2  broadcast dispatch code: 11 clear, 01 dispatch, 10 hold, 00 run/clear-neighbors.
- double_buffer  out  1  active position-buffer half.
- nbr_valid  out  1  node neighbor outputs are valid.
- busy  out  1  high in every state except IDLE.
- step_done  out  1  one-cycle pulse per completed timestep.
- run_done  out  1  one-cycle pulse when the run completes.
- step_count  out  TSW  timesteps completed in the current run.
- batch_count  out  16  batches dispatched in the current timestep.

Behaviour:
- Reset values (async, reset==0): state=IDLE, dispatch=00, double_buffer=0, and every other output 0. Re-entering reset mid-run aborts immediately to IDLE; there is no partial-state recovery.
- All outputs are registered and change only on the rising edge of clk.
- Quiet condition: &node_done_batch && ~|node_in_flight. A quiet counter increments on each quiet cycle and clears otherwise. "Batch finished" means the counter has reached DRAIN.
- IDLE: dispatch=00. On start: latch max(num_steps,1), clear step_count, go to CLEAR.
- CLEAR (1 cycle): dispatch=11, clear batch_count, go to DISPATCH.
- DISPATCH (1 cycle): dispatch=01, increment batch_count.
  - If the flag fin (set on entry from WAIT_Q with &node_done_all) is set, go to FLUSH_ACK.
  - Otherwise go to RUN_ACK.
- RUN_ACK: dispatch=10 and nbr_valid=1.
  - Exception: if batch_count==1, the neighbor sets are the reset pattern. Skip the handshake, hold nbr_valid=0 and go straight to WAIT_Q.
  - On nbr_ack: nbr_valid falls next cycle, go to WAIT_Q.
- WAIT_Q: dispatch=00. Clear the quiet counter on entry.
  - When the batch is finished: go to DISPATCH. Set fin if &node_done_all was true in the same cycle.
  - Partial done_all (some nodes only) counts as not finished; keep iterating.
- FLUSH_ACK: dispatch=10 and nbr_valid=1. On nbr_ack go to SWAP.
- SWAP: dispatch=00. Wait for swap_ok. On the edge where swap_ok==1:
  - toggle double_buffer;
  - increment step_count;
  - pulse step_done;
  - clear fin.
  - If step_count+1 == the latched step count: pulse run_done and go to IDLE.
  - Otherwise go to CLEAR.
- double_buffer changes only in SWAP, so it is stable for the whole timestep.
- Simultaneous events:
  - nbr_ack in the same cycle nbr_valid rises is accepted.
  - swap_ok held high continuously gives exactly one swap per SWAP visit.
  - start while busy is ignored.
- batch_count saturates at 0xFFFF. step_count wraps only beyond TSW bits; unreachable by construction.
- Latencies:
  - start → dispatch=11: 1 cycle.
  - Batch finished → next dispatch=01: 1 cycle.
  - swap_ok → CLEAR: 1 cycle.

Decomposition:
- Shared package (md_pkg) holds:
  - dispatch code constants DISP_CLEAR=2'b11, DISP_GO=2'b01, DISP_HOLD=2'b10, DISP_RUN=2'b00;
  - the state enum;
  - the NNODES default.
- One natural sub-module: ring_quiet_detect. It performs the AND/OR reduction plus the DRAIN counter and outputs a batch-finished pulse.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 → all outputs 0, dispatch=00, state IDLE; release reset → still IDLE until a new start.
- Single step: NNODES=4, num_steps=1, nodes go quiet 5 cycles after each dispatch, done_all after batch 3, nbr_ack 2 cycles after nbr_valid, swap_ok=1 → dispatch sequence 11,01,00…,01,10…,00…,01,10… with batch_count=4; step_done and run_done pulse together; double_buffer=1.
- Drain guard: quiet for 1 cycle, then in_flight[2] rises, then quiet for 2 cycles → no dispatch until the second continuous quiet run reaches 2.
- Partial done_all: done_all=4'b0111 when quiet → normal DISPATCH with no fin; all 1s at the next quiet → flush path taken.
- Swap stall: swap_ok=0 for 20 cycles → controller stays in SWAP, double_buffer unchanged; swap_ok=1 → toggles next edge; num_steps=3 gives double_buffer 0→1→0→1 and step_done ×3.
- Mid-run reset and busy start: assert reset during RUN_ACK → outputs 0 asynchronously; start pulses during busy leave step_count unaffected.
